// File: rtl/inv_round_iter.sv
// Iterative AES inverse cipher: one FIPS-197 inverse round per clock, with round keys
// fetched in descending order (NR..0) over a request/acknowledge port.
module inv_round_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_data_in,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_data_out,
  output logic         o_key_req,
  output logic [3:0]   o_key_idx,
  input  logic         i_key_ack,
  input  logic [127:0] i_key_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bit 2047-8*b, i.e. {~b, 3'b111}.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [127:0]   r_st;
  logic [127:0]   w_st_nxt;
  logic [3:0]     r_rnd;
  logic [3:0]     w_rnd_nxt;
  logic [127:0]   w_ark;
  logic [127:0]   w_imc;

  assign w_ark = inv_sub_bytes(inv_shift_rows(r_st)) ^ i_key_in;
  assign w_imc = inv_mix_columns(w_ark);

  // Next-state and datapath update; round NR is the bare key add, round 0 skips InvMixColumns.
  always_comb begin
    w_state_nxt = r_state;
    w_st_nxt    = r_st;
    w_rnd_nxt   = r_rnd;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_st_nxt    = i_data_in;
          w_rnd_nxt   = NR_L;
          w_state_nxt = S_KEY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_KEY: begin
        if (i_key_ack) begin
          if (r_rnd == NR_L) begin
            w_st_nxt = r_st ^ i_key_in;
          end else if (r_rnd == 4'd0) begin
            w_st_nxt = w_ark;
          end else begin
            w_st_nxt = w_imc;
          end
          if (r_rnd == 4'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rnd_nxt = r_rnd - 4'd1;
          end
        end else begin
          w_state_nxt = S_KEY;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Working state and round counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_st  <= 128'd0;
      r_rnd <= 4'd0;
    end else begin
      r_st  <= w_st_nxt;
      r_rnd <= w_rnd_nxt;
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_key_req   = (r_state == S_KEY);
  assign o_key_idx   = r_rnd;
  assign o_out_valid = (r_state == S_DONE);
  assign o_data_out  = r_st;

endmodule

// File: tb/tb_inv_round_iter.sv
// Directed bench for inv_round_iter: FIPS-197 vectors, key stalls, backpressure,
// mid-block reset and random blocks checked against a forward-cipher model.
module tb_inv_round_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic [127:0] data_in;
  logic         out_ready;
  logic         key_ack;
  logic [127:0] key_in;
  logic         sel14;

  logic         in_valid_a, in_ready_a, out_valid_a, key_req_a;
  logic [127:0] data_out_a;
  logic [3:0]   key_idx_a;
  logic         in_valid_b, in_ready_b, out_valid_b, key_req_b;
  logic [127:0] data_out_b;
  logic [3:0]   key_idx_b;

  logic         in_ready, out_valid, key_req;
  logic [127:0] data_out;
  logic [3:0]   key_idx;

  assign in_valid_a = in_valid & ~sel14;
  assign in_valid_b = in_valid & sel14;
  assign in_ready   = sel14 ? in_ready_b  : in_ready_a;
  assign out_valid  = sel14 ? out_valid_b : out_valid_a;
  assign key_req    = sel14 ? key_req_b   : key_req_a;
  assign key_idx    = sel14 ? key_idx_b   : key_idx_a;
  assign data_out   = sel14 ? data_out_b  : data_out_a;

  inv_round_iter #(.NR(10)) dut10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_a), .o_in_ready(in_ready_a),
    .i_data_in(data_in), .o_out_valid(out_valid_a), .i_out_ready(out_ready),
    .o_data_out(data_out_a), .o_key_req(key_req_a), .o_key_idx(key_idx_a),
    .i_key_ack(key_ack), .i_key_in(key_in)
  );

  inv_round_iter #(.NR(14)) dut14 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
    .i_data_in(data_in), .o_out_valid(out_valid_b), .i_out_ready(out_ready),
    .o_data_out(data_out_b), .o_key_req(key_req_b), .o_key_idx(key_idx_b),
    .i_key_ack(key_ack), .i_key_in(key_in)
  );

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] rk [0:14];
  int n_chk  = 0;
  int n_pass = 0;
  int n_in   = 0;
  int n_out  = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // Forward cipher with the current key schedule; used to make ciphertexts for random blocks.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < nr; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
    return shift_rows(sub_bytes(s)) ^ rk[nr];
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
  endtask

  // One block through the core: key stalls at stall_at, bp_len cycles of out_ready=0,
  // or random ack/out_ready when rnd is set. key_ack stays high with junk keys outside KEY.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int stall_at,
                           input int stall_len, input int bp_len, input bit rnd, input string tag);
    int nr, exp_idx, stalls, lat, waits, hold;
    nr = sel14 ? 14 : 10;
    waits = 0;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk_eq({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    data_in  = ct;
    key_ack  = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    n_in++;
    exp_idx = nr;
    stalls  = 0;
    lat     = 1;
    while (!out_valid && lat < 100) begin
      in_valid = (bp_len > 0);
      data_in  = ~ct;
      if (key_req) begin
        chk_eq({tag, "_key_idx"}, key_idx, exp_idx[3:0]);
        if ((!rnd && key_idx == stall_at[3:0] && stalls < stall_len) ||
            (rnd && $urandom_range(0, 2) == 0)) begin
          key_ack = 1'b0;
          key_in  = {$urandom, $urandom, $urandom, $urandom};
          stalls++;
        end else begin
          key_ack = 1'b1;
          key_in  = rk[key_idx];
          exp_idx--;
        end
      end else begin
        key_ack = 1'b1;
        key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      lat++;
    end
    chk_eq({tag, "_out_valid"}, out_valid, 1'b1);
    chk_eq({tag, "_latency"}, lat, nr + 2 + stalls);
    chk_eq({tag, "_keys_used"}, nr - exp_idx, nr + 1);
    chk_eq({tag, "_data_out"}, data_out, pt);
    hold = 0;
    for (int k = 0; k < 60; k++) begin
      if (hold < bp_len) out_ready = 1'b0;
      else if (rnd) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      in_valid = (bp_len > 0);
      data_in  = ~ct;
      tick();
      if (out_ready) begin
        n_out++;
        break;
      end
      hold++;
      chk_eq({tag, "_hold_valid"}, out_valid, 1'b1);
      chk_eq({tag, "_hold_data"}, data_out, pt);
      chk_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_eq({tag, "_back_to_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    logic [127:0] pt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 128'd0;
    out_ready = 1'b0;
    key_ack   = 1'b0;
    key_in    = 128'd0;
    sel14     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_eq("rst_in_ready", in_ready, 1'b1);
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_key_req", key_req, 1'b0);
    chk_eq("rst_key_idx", key_idx, 4'd0);
    chk_eq("rst_data_out", data_out, 128'd0);
    chk_eq("rst14_state", {in_ready_b, out_valid_b, key_req_b}, 3'b100);

    expand_key(C1_KEY, 4, 10);
    run_block(C1_CT, PT_REF, -1, 0, 0, 1'b0, "c1");
    run_block(C1_CT, PT_REF, 5, 3, 0, 1'b0, "stall");
    run_block(C1_CT, PT_REF, -1, 0, 5, 1'b0, "bp");
    run_block(C1_CT, PT_REF, -1, 0, 0, 1'b0, "after_bp");

    // Reset while round key 4 is being requested.
    in_valid = 1'b1;
    data_in  = C1_CT;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!(key_req && key_idx == 4'd4) && lat < 40) begin
      key_ack = 1'b1;
      key_in  = rk[key_idx];
      tick();
      lat++;
    end
    chk_eq("mid_reached_rnd4", {key_req, key_idx}, 5'h14);
    rst_n = 1'b0;
    key_ack = 1'b1;
    key_in  = rk[4];
    tick();
    rst_n = 1'b1;
    chk_eq("mid_rst_in_ready", in_ready, 1'b1);
    chk_eq("mid_rst_out_valid", out_valid, 1'b0);
    chk_eq("mid_rst_key_req", key_req, 1'b0);
    chk_eq("mid_rst_data_out", data_out, 128'd0);
    tick();
    chk_eq("mid_rst_no_req", {key_req, in_ready}, 2'b01);
    run_block(C1_CT, PT_REF, -1, 0, 0, 1'b0, "after_rst");

    for (int b = 0; b < 200; b++) begin
      expand_key({$urandom, $urandom, $urandom, $urandom, 128'd0}, 4, 10);
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block(encrypt(pt, 10), pt, -1, 0, 0, 1'b1, "rand");
    end
    chk_eq("in_out_count", n_out, n_in);

    sel14 = 1'b1;
    expand_key(C3_KEY, 8, 14);
    run_block(C3_CT, PT_REF, -1, 0, 0, 1'b0, "c3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_round_iter.md
# inv_round_iter

Iterative AES inverse cipher core: takes a 128-bit ciphertext block and produces the plaintext by applying the FIPS-197 inverse cipher one round per clock. It is the decrypt-side counterpart of the forward round datapath (AddRoundKey, SubBytes, ShiftRows, MixColumns). Round keys are fetched one at a time, in descending index order, from the key expander over a request/acknowledge port. It sits between the block-level ciphertext source and the plaintext sink, with valid/ready handshakes on both sides.

## Interface
- NR, 10: number of cipher rounds. Legal values are 10, 12 and 14. Round keys used are NR down to 0.
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  ciphertext on data_in is valid.
- in_ready  output  1  core can accept a block. High only in IDLE.
- data_in  input  128  ciphertext. Byte 0 is bits [127:120]; state is column-major per FIPS-197.
- out_valid  output  1  plaintext on data_out is valid.
- out_ready  input  1  sink accepts the plaintext.
- data_out  output  128  plaintext, same byte order as data_in.
- key_req  output  1  requesting round key key_idx.
- key_idx  output  4  index of the requested round key.
- key_ack  input  1  key_in holds round key key_idx in this cycle.
- key_in  input  128  round key, same byte order.

## Operation
- State registers:
  - st[127:0], the working state.
  - rnd[3:0], the round counter.
  - FSM, one of IDLE, KEY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: st<=data_in, rnd<=NR, go to KEY.
- KEY:
  - key_req=1 and key_idx=rnd. Keep holding both until key_ack.
  - On key_ack, update st according to rnd:
    - rnd==NR: st <= st ^ key_in.
    - 0<rnd<NR: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ key_in).
    - rnd==0: st <= InvSubBytes(InvShiftRows(st)) ^ key_in. Then go to DONE.
  - If rnd!=0, decrement rnd and stay in KEY.
  - Without key_ack, st and rnd hold.
- DONE:
  - out_valid=1 and data_out=st.
  - On out_ready: go to IDLE.
- InvShiftRows rotates row r right by r byte positions.
- InvSubBytes is the FIPS-197 inverse S-box, applied to all 16 bytes.
- InvMixColumns uses the GF(2^8) matrix {0e,0b,0d,09} with reduction polynomial 0x11b.
- All three transforms are combinational within one cycle.
- key_ack while key_req=0 is ignored.
- in_valid outside IDLE is ignored. The block is not accepted and no data is lost, because in_ready=0.
- While out_ready=0, data_out is held stable.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - FSM=IDLE, st=0, rnd=0.
  - in_ready=1, out_valid=0, key_req=0, key_idx=0, data_out=0.
- Reset mid-operation discards the block in flight. The next cycle is IDLE with the outputs above. No further keys are requested.
- key_req, key_idx, in_ready and out_valid are decoded from registered FSM/rnd only, not from same-cycle inputs.
- data_out is driven from st.
- Latency with key_ack held high:
  - Accept edge at cycle 0.
  - Key cycles 1..NR+1.
  - out_valid high from cycle NR+2 (12 for NR=10).
- Throughput is one block per NR+3 cycles when out_ready=1. in_ready rises the cycle after the out_valid/out_ready handshake.
- Each key wait-state adds exactly one cycle. Key indices are requested strictly NR, NR-1, …, 0, and each exactly once per block.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: data_in=69c4e0d86a7b0430d8cdb78070b4c55a, keys from the model for 000102030405060708090a0b0c0d0e0f, key_ack=1.
  - Response: out_valid at cycle 12 with data_out=00112233445566778899aabbccddeeff. key_idx sequence observed as 10..0.
- Key stall:
  - Stimulus: same vector, key_ack deasserted for 3 cycles at rnd=5.
  - Response: key_idx=5 held and st unchanged; out_valid at cycle 15 with the same plaintext.
- Output backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE, and in_valid=1 throughout.
  - Response: data_out stable, in_ready=0, no new block captured. After out_ready=1, IDLE, then the next block is accepted.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge at rnd=4.
  - Response: next cycle in_ready=1, out_valid=0, key_req=0, data_out=0. A following C.1 run gives the correct plaintext.
- Back-to-back with random stalls:
  - Stimulus: 200 random ciphertext/key pairs, random key_ack and out_ready.
  - Response: every data_out matches the reference decryption, and the count of outputs equals the count of inputs.
- NR=14:
  - Stimulus: FIPS-197 C.3 vector (ct 8ea2b7ca516745bfeafc49904b496089).
  - Response: plaintext 00112233445566778899aabbccddeeff at cycle 16.
